// File: rtl/ahb_arbiter_slave_7.sv
// Round-robin AHB arbiter for slave_7: registered one-hot address-phase grant,
// burst-aware release with beat counter, and a data-phase select pipeline.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no channel owns slave_7, sel is all-zero
// ST_OWNED | channel last_owner owns slave_7, sel is one-hot
module ahb_arbiter_slave_7 #(
  parameter int CHANNEL_NUM = 2
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [CHANNEL_NUM-1:0]      req,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst,
  input  logic                        hready_in,
  output logic [CHANNEL_NUM-1:0]      sel,
  output logic [CHANNEL_NUM-1:0]      sel_data,
  output logic                        busy
);

  localparam int IW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t                 state_q, state_nxt;
  logic [CHANNEL_NUM-1:0] sel_q, sel_nxt;
  logic [CHANNEL_NUM-1:0] sel_data_q;
  logic [IW-1:0]          last_owner_q, last_owner_nxt;
  logic [3:0]             cnt_q, cnt_nxt;
  logic                   open_q, open_nxt;

  logic [IW-1:0]          win_idx;
  logic                   win_found;
  logic [CHANNEL_NUM-1:0] win_hot;
  logic [3:0]             burst_len;
  logic                   release_now;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    logic [IW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      idx = IW'((int'(last_owner_q) + k) % CHANNEL_NUM);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    win_hot = {{(CHANNEL_NUM-1){1'b0}}, 1'b1} << win_idx;
  end

  always_comb begin
    case (hburst[last_owner_q][2:1])
      2'b01:   burst_len = 4'd3;
      2'b10:   burst_len = 4'd7;
      2'b11:   burst_len = 4'd15;
      default: burst_len = 4'd0;
    endcase
  end

  // open_q marks an owner with no fixed length yet (INCR, or granted but no
  // NONSEQ seen); such an owner gives the bus back on an IDLE transfer.
  always_comb begin
    state_nxt      = state_q;
    sel_nxt        = sel_q;
    last_owner_nxt = last_owner_q;
    cnt_nxt        = cnt_q;
    open_nxt       = open_q;
    release_now    = 1'b0;
    if (hready_in) begin
      if (state_q == ST_IDLE) begin
        release_now = 1'b1;
      end else if (!req[last_owner_q]) begin
        release_now = 1'b1;
      end else begin
        case (htrans[last_owner_q])
          TR_NONSEQ: begin
            if (hburst[last_owner_q] == HB_INCR) begin
              open_nxt = 1'b1;
              cnt_nxt  = 4'd0;
            end else begin
              open_nxt = 1'b0;
              cnt_nxt  = burst_len;
              if (burst_len == 4'd0) release_now = 1'b1;
            end
          end
          TR_SEQ: begin
            if (!open_q) begin
              if (cnt_q <= 4'd1) release_now = 1'b1;
              if (cnt_q != 4'd0) cnt_nxt = cnt_q - 4'd1;
            end
          end
          TR_IDLE: if (open_q) release_now = 1'b1;
          TR_BUSY: ;
          default: ;
        endcase
      end
      if (release_now) begin
        open_nxt = 1'b1;
        cnt_nxt  = 4'd0;
        if (win_found) begin
          state_nxt      = ST_OWNED;
          sel_nxt        = win_hot;
          last_owner_nxt = win_idx;
        end else begin
          state_nxt = ST_IDLE;
          sel_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      sel_data_q   <= '0;
      last_owner_q <= IW'(CHANNEL_NUM - 1);
      cnt_q        <= 4'd0;
      open_q       <= 1'b1;
    end else begin
      state_q      <= state_nxt;
      sel_q        <= sel_nxt;
      last_owner_q <= last_owner_nxt;
      cnt_q        <= cnt_nxt;
      open_q       <= open_nxt;
      if (hready_in) sel_data_q <= sel_q;
    end
  end

  assign sel      = sel_q;
  assign sel_data = sel_data_q;
  assign busy     = |sel_q;

endmodule

// File: doc/ahb_arbiter_slave_7.md
AHB_ARBITER_SLAVE_7 -- requirements
Module: ahb_arbiter_slave_7

Interface
REQ-001 The block SHALL have parameter CHANNEL_NUM, default 2, giving the number of master channels competing for slave_7.
REQ-002 HCLK  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 HRESETn  input  1  is the reset, which SHALL be synchronous and active-low.
REQ-004 req  input  [CHANNEL_NUM-1:0]  per-channel request: master i addresses slave_7.
REQ-005 htrans  input  [CHANNEL_NUM-1:0][1:0]  per-channel HTRANS: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 hburst  input  [CHANNEL_NUM-1:0][2:0]  per-channel HBURST: SINGLE=000, INCR=001, WRAP4/INCR4=010/011, WRAP8/INCR8=100/101, WRAP16/INCR16=110/111.
REQ-007 hready_in  input  1  slave-side HREADY; a beat is accepted only when it is 1.
REQ-008 sel  output  [CHANNEL_NUM-1:0]  one-hot address-phase grant; drives the slave_7 payload mux select.
REQ-009 sel_data  output  [CHANNEL_NUM-1:0]  one-hot data-phase select; drives the response return path.
REQ-010 busy  output  1  high while any channel owns slave_7.

Function
REQ-011 The block SHALL implement states IDLE (no owner) and OWNED (one owner, sel nonzero); sel SHALL be registered, one-hot or all-zero, never multi-hot.
REQ-012 IDLE->OWNED: when req is nonzero and hready_in=1, the block SHALL set sel to the winner on the next edge, a 1-cycle grant latency.
REQ-013 Winner selection SHALL be round-robin: search starts at last_owner+1 modulo CHANNEL_NUM; last_owner resets to CHANNEL_NUM-1, so channel 0 wins first.
REQ-014 Accepted owner beat: sel[i]=1, hready_in=1, htrans[i] NONSEQ or SEQ.
REQ-015 On an accepted NONSEQ, a beat counter SHALL load beats-1: 3 for 4-beat bursts, 7 for 8-beat, 15 for 16-beat, 0 for SINGLE; for INCR it is unused.
REQ-016 Each accepted SEQ SHALL decrement the counter; the counter SHALL NOT decrement on BUSY, IDLE or hready_in=0.
REQ-017 Fixed-length burst and SINGLE SHALL release ownership on the edge that accepts the beat with counter=0.
REQ-018 INCR SHALL release on the edge where hready_in=1 and the owner drives htrans=IDLE or req[owner]=0.
REQ-019 Early termination: req[owner]=0 with hready_in=1 mid fixed burst SHALL release immediately.
REQ-020 On release, the same edge SHALL re-arbitrate per REQ-013 over current req with no dead cycle; sel goes to 0 and state to IDLE only if req is 0.
REQ-021 The sole remaining requester MAY be re-granted after release (RR from owner+1 wraps back to it).
REQ-022 hready_in=0 SHALL freeze sel, state, counter and last_owner.
REQ-023 sel_data SHALL load sel on every edge with hready_in=1 and SHALL hold while hready_in=0, giving the AHB one-cycle address-to-data pipeline.
REQ-024 busy SHALL equal |sel.
REQ-025 Requests from non-owners SHALL never affect an ongoing burst; there is no preemption.

Reset
REQ-026 With HRESETn=0 at an edge: sel=0, sel_data=0, busy=0, state=IDLE, counter=0, last_owner=CHANNEL_NUM-1.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration restarts per REQ-012.

Verification
REQ-028 Reset, then req=01, hready_in=1 -> sel=01 one cycle later; sel_data=01 one cycle after that; busy=1.
REQ-029 req=11 from IDLE, ch0 INCR4 (NONSEQ + 3 SEQ, hready_in=1) -> sel=01 for 4 beats; on the 4th-beat edge sel=10 with no gap.
REQ-030 Owner ch1 WRAP8, hready_in=0 for 3 cycles at beat 5 -> sel, counter and sel_data frozen; burst completes after 8 accepted beats total.
REQ-031 ch0 INCR with BUSY inserted, then htrans=IDLE, req=00 -> ownership held through BUSY; sel=00, busy=0 after the IDLE edge.
REQ-032 ch1 INCR16, req[1] dropped at beat 6, req[0]=1 -> sel=01 on that edge.
REQ-033 HRESETn=0 at beat 2 of an INCR8 -> all outputs 0 next edge; after release, req=10 grants sel=10 per REQ-012.
